// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared FSM state type and default parameters for the GCD unit
package gcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_t;

    localparam int GCD_W_DEF        = 32;
    localparam int GCD_CW_DEF       = 16;
    localparam int GCD_EARLY_EQ_DEF = 1;

endpackage

// File: rtl/gcd_unit_hs_dpath.sv
// rtl/gcd_unit_hs_dpath.sv - A/B operand registers, swap/subtract muxing and comparators
module gcd_unit_hs_dpath
    import gcd_pkg::*;
#(
    parameter int W = GCD_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         swap,
    input  logic         sub,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [W-1:0] a,
    output logic         a_lt_b,
    output logic         a_eq_b,
    output logic         b_zero
);

    logic [W-1:0] b;

    // Control guarantees at most one of load/swap/sub per cycle; load wins regardless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a <= '0;
            b <= '0;
        end else if (load) begin
            a <= req_a;
            b <= req_b;
        end else if (swap) begin
            a <= b;
            b <= a;
        end else if (sub) begin
            a <= a - b;
        end
    end

    assign a_lt_b = (a < b);
    assign a_eq_b = (a == b);
    assign b_zero = (b == '0);

endmodule

// File: rtl/gcd_unit_hs.sv
// rtl/gcd_unit_hs.sv - handshaked subtractive GCD unit with saturating iteration counter
module gcd_unit_hs
    import gcd_pkg::*;
#(
    parameter int W        = GCD_W_DEF,
    parameter int CW       = GCD_CW_DEF,
    parameter int EARLY_EQ = GCD_EARLY_EQ_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_val,
    output logic          req_rdy,
    input  logic [W-1:0]  req_a,
    input  logic [W-1:0]  req_b,
    output logic          resp_val,
    input  logic          resp_rdy,
    output logic [W-1:0]  resp_data,
    output logic [CW-1:0] resp_cnt,
    output logic          busy
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    gcd_state_t    state, state_next;
    logic [CW-1:0] cnt;
    logic          load, swap, sub;
    logic [W-1:0]  a;
    logic          a_lt_b, a_eq_b, b_zero;

    gcd_unit_hs_dpath #(.W(W)) u_dpath (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .swap    (swap),
        .sub     (sub),
        .req_a   (req_a),
        .req_b   (req_b),
        .a       (a),
        .a_lt_b  (a_lt_b),
        .a_eq_b  (a_eq_b),
        .b_zero  (b_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        swap       = 1'b0;
        sub        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_val) begin
                    load       = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                // Swap first keeps A >= B, so the subtract below can never underflow.
                if (a_lt_b) begin
                    swap = 1'b1;
                end else if (b_zero) begin
                    state_next = ST_DONE;
                end else if ((EARLY_EQ != 0) && a_eq_b) begin
                    state_next = ST_DONE;
                end else begin
                    sub = 1'b1;
                end
            end
            ST_DONE: begin
                if (resp_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if ((swap || sub) && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign req_rdy   = (state == ST_IDLE);
    assign resp_val  = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign resp_data = a;
    assign resp_cnt  = cnt;

endmodule

// File: tb/tb_gcd_unit_hs.sv
// tb/tb_gcd_unit_hs.sv - vector table and scoreboard bench for gcd_unit_hs
module tb_gcd_unit_hs;

    logic        clk;
    logic        reset_n;
    logic        req_val  [3];
    logic        req_rdy  [3];
    logic [31:0] req_a    [3];
    logic [31:0] req_b    [3];
    logic        resp_val [3];
    logic        resp_rdy [3];
    logic [31:0] resp_data[3];
    logic        busy     [3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        int          cnt;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        int          exp_cnt;
        int          exp_lat;
    } vec_t;

    // dut 0: EARLY_EQ=1, dut 1: EARLY_EQ=0, dut 2: CW=4
    gcd_unit_hs #(.W(32), .CW(16), .EARLY_EQ(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .req_val(req_val[0]), .req_rdy(req_rdy[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]),
        .resp_data(resp_data[0]), .resp_cnt(cnt0), .busy(busy[0])
    );
    gcd_unit_hs #(.W(32), .CW(16), .EARLY_EQ(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req_val(req_val[1]), .req_rdy(req_rdy[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]),
        .resp_data(resp_data[1]), .resp_cnt(cnt1), .busy(busy[1])
    );
    gcd_unit_hs #(.W(32), .CW(4), .EARLY_EQ(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req_val(req_val[2]), .req_rdy(req_rdy[2]),
        .req_a(req_a[2]), .req_b(req_b[2]), .resp_val(resp_val[2]), .resp_rdy(resp_rdy[2]),
        .resp_data(resp_data[2]), .resp_cnt(cnt2), .busy(busy[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cnt_of(input int d);
        case (d)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        exp_t e;
        n = 0;
        while (!req_rdy[v.d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_rdy_before_accept", 32'(req_rdy[v.d]), 32'd1);
        req_a[v.d]   = v.a;
        req_b[v.d]   = v.b;
        req_val[v.d] = 1'b1;
        sb_q.push_back('{data: v.exp_data, cnt: v.exp_cnt});
        @(posedge clk); #1;
        req_val[v.d] = 1'b0;
        n = 0;
        while (!resp_val[v.d] && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(v.exp_lat));
        e = sb_q.pop_front();
        chk("resp_data", resp_data[v.d], e.data);
        chk("resp_cnt", 32'(cnt_of(v.d)), 32'(e.cnt));
        resp_rdy[v.d] = 1'b1;
        @(posedge clk); #1;
        resp_rdy[v.d] = 1'b0;
        chk("idle_after_handshake", {30'd0, req_rdy[v.d], resp_val[v.d]}, 32'b10);
    endtask

    vec_t vecs[8];

    initial begin
        int   n;
        exp_t e;

        vecs[0] = '{d: 0, a: 15,  b: 5,  exp_data: 5, exp_cnt: 2,  exp_lat: 3};
        vecs[1] = '{d: 1, a: 15,  b: 5,  exp_data: 5, exp_cnt: 4,  exp_lat: 5};
        vecs[2] = '{d: 0, a: 0,   b: 7,  exp_data: 7, exp_cnt: 1,  exp_lat: 2};
        vecs[3] = '{d: 0, a: 7,   b: 0,  exp_data: 7, exp_cnt: 0,  exp_lat: 1};
        vecs[4] = '{d: 0, a: 0,   b: 0,  exp_data: 0, exp_cnt: 0,  exp_lat: 1};
        vecs[5] = '{d: 2, a: 100, b: 1,  exp_data: 1, exp_cnt: 15, exp_lat: 100};
        vecs[6] = '{d: 0, a: 48,  b: 18, exp_data: 6, exp_cnt: 6,  exp_lat: 7};
        vecs[7] = '{d: 1, a: 12,  b: 8,  exp_data: 4, exp_cnt: 5,  exp_lat: 6};

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_val[i]  = 1'b0;
            req_a[i]    = '0;
            req_b[i]    = '0;
            resp_rdy[i] = 1'b0;
        end
        #2;
        chk("reset_req_rdy", 32'(req_rdy[0]), 32'd1);
        chk("reset_resp_val", 32'(resp_val[0]), 32'd0);
        chk("reset_resp_data", resp_data[0], 32'd0);
        chk("reset_resp_cnt", 32'(cnt0), 32'd0);
        chk("reset_busy", 32'(busy[0]), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result held for 10 cycles, req_val presented mid-flight must be ignored.
        req_a[0]   = 27;
        req_b[0]   = 36;
        req_val[0] = 1'b1;
        sb_q.push_back('{data: 9, cnt: 5});
        @(posedge clk); #1;
        req_a[0] = 99;
        req_b[0] = 33;
        n = 0;
        while (!resp_val[0] && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("hold_latency", 32'(n), 32'd6);
        e = sb_q.pop_front();
        for (int k = 0; k < 10; k++) begin
            chk("hold_stable", {resp_val[0], req_rdy[0], busy[0], resp_data[0][28:0]},
                {1'b1, 1'b0, 1'b1, e.data[28:0]});
            chk("hold_cnt", 32'(cnt0), 32'(e.cnt));
            @(posedge clk); #1;
        end
        req_val[0]  = 1'b0;
        resp_rdy[0] = 1'b1;
        chk("hold_rdy_in_handshake_cycle", 32'(req_rdy[0]), 32'd0);
        @(posedge clk); #1;
        resp_rdy[0] = 1'b0;
        chk("hold_rdy_after_handshake", 32'(req_rdy[0]), 32'd1);
        @(posedge clk); #1;
        chk("hold_no_stray_accept", 32'(busy[0]), 32'd0);

        // Reset pulse in the middle of CALC aborts with no response.
        req_a[0]   = 48;
        req_b[0]   = 18;
        req_val[0] = 1'b1;
        @(posedge clk); #1;
        req_val[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_busy", 32'(busy[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_state", {29'd0, req_rdy[0], busy[0], resp_val[0]}, 32'b100);
        chk("async_reset_cnt", 32'(cnt0), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (resp_val[0] || busy[0]) n++;
            @(posedge clk); #1;
        end
        chk("no_resp_after_abort", 32'(n), 32'd0);
        run_vec(vecs[6]);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
